// File: rtl/game_control.sv
// Frame sequencer for the obstacle dodger: runs the draw/wait/erase/update loop and
// tracks lives, level, collision and goal events through to game over or win.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | after reset, waiting for the start key
//   S_LOAD   | start key held; lives and level loaded
//   S_DRAW   | plot sprite colour, PIXELS cycles
//   S_WAIT   | frame delay, FRAME_TICKS cycles, then event decision
//   S_ERASE  | plot background colour, PIXELS cycles
//   S_UPDATE | single-cycle datapath advance
//   S_HIT    | collision indication held HIT_HOLD cycles
//   S_LEVEL  | single-cycle level advance or win decision
//   S_OVER   | no lives left, waiting for restart
//   S_WIN    | last level cleared, waiting for restart
module game_control #(
    parameter int FRAME_TICKS = 833333,
    parameter int PIXELS      = 16,
    parameter int LIVES       = 3,
    parameter int LEVELS      = 4,
    parameter int HIT_HOLD    = 25000000,
    localparam int PW = $clog2(PIXELS),
    localparam int LW = $clog2(LIVES + 1),
    localparam int VW = $clog2(LEVELS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld,
    input  logic          collide,
    input  logic          goal,
    output logic          writeEnable,
    output logic          draw,
    output logic [PW-1:0] pix_count,
    output logic          update,
    output logic          respawn,
    output logic [LW-1:0] lives,
    output logic [VW-1:0] level,
    output logic          hit,
    output logic          game_over,
    output logic          win
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_DRAW   = 4'd2;
    localparam logic [3:0] S_WAIT   = 4'd3;
    localparam logic [3:0] S_ERASE  = 4'd4;
    localparam logic [3:0] S_UPDATE = 4'd5;
    localparam logic [3:0] S_HIT    = 4'd6;
    localparam logic [3:0] S_LEVEL  = 4'd7;
    localparam logic [3:0] S_OVER   = 4'd8;
    localparam logic [3:0] S_WIN    = 4'd9;

    // One down-counter serves both the frame wait and the hit hold.
    localparam int TMAX = (FRAME_TICKS > HIT_HOLD) ? FRAME_TICKS : HIT_HOLD;
    localparam int TW   = $clog2(TMAX);

    logic [3:0]    state;
    logic [TW-1:0] tmr;
    logic          col_flag;
    logic          goal_flag;
    logic          play_phase;
    logic          pix_last;
    logic          tmr_done;

    assign play_phase = (state == S_DRAW) || (state == S_WAIT) ||
                        (state == S_ERASE) || (state == S_UPDATE);
    assign pix_last   = (pix_count == PW'(PIXELS - 1));
    assign tmr_done   = (tmr == '0);

    assign writeEnable = (state == S_DRAW) || (state == S_ERASE);
    assign draw        = (state == S_DRAW);
    assign update      = (state == S_UPDATE);
    assign hit         = (state == S_HIT);
    assign game_over   = (state == S_OVER);
    assign win         = (state == S_WIN);
    assign respawn     = ((state == S_HIT) && tmr_done && (lives != '0)) ||
                         ((state == S_LEVEL) && (level != VW'(LEVELS)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tmr       <= '0;
            pix_count <= '0;
            lives     <= '0;
            level     <= '0;
            col_flag  <= 1'b0;
            goal_flag <= 1'b0;
        end else begin
            if (play_phase) begin
                if (collide) col_flag  <= 1'b1;
                if (goal)    goal_flag <= 1'b1;
            end
            case (state)
                S_IDLE, S_OVER, S_WIN: begin
                    if (ld) begin
                        state <= S_LOAD;
                        lives <= LW'(LIVES);
                        level <= VW'(1);
                    end
                end
                S_LOAD: begin
                    if (!ld) begin
                        state     <= S_DRAW;
                        pix_count <= '0;
                    end
                end
                S_DRAW: begin
                    if (pix_last) begin
                        state     <= S_WAIT;
                        pix_count <= '0;
                        tmr       <= TW'(FRAME_TICKS - 1);
                    end else begin
                        pix_count <= pix_count + PW'(1);
                    end
                end
                S_WAIT: begin
                    if (tmr_done) begin
                        // Clearing wins over an event arriving on the decision cycle.
                        col_flag  <= 1'b0;
                        goal_flag <= 1'b0;
                        if (col_flag) begin
                            state <= S_HIT;
                            tmr   <= TW'(HIT_HOLD - 1);
                            if (lives != '0) lives <= lives - LW'(1);
                        end else if (goal_flag) begin
                            state <= S_LEVEL;
                        end else begin
                            state     <= S_ERASE;
                            pix_count <= '0;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_ERASE: begin
                    if (pix_last) begin
                        state     <= S_UPDATE;
                        pix_count <= '0;
                    end else begin
                        pix_count <= pix_count + PW'(1);
                    end
                end
                S_UPDATE: begin
                    state     <= S_DRAW;
                    pix_count <= '0;
                end
                S_HIT: begin
                    if (tmr_done) begin
                        if (lives == '0) begin
                            state <= S_OVER;
                        end else begin
                            state     <= S_ERASE;
                            pix_count <= '0;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_LEVEL: begin
                    if (level == VW'(LEVELS)) begin
                        state <= S_WIN;
                    end else begin
                        level     <= level + VW'(1);
                        state     <= S_ERASE;
                        pix_count <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed game scenarios plus random play, all compared each
// cycle against a phase/remaining-cycles model of the game rules.
module tb_game_control;

    localparam int FT  = 4;
    localparam int PIX = 16;
    localparam int LIV = 3;
    localparam int LVL = 2;
    localparam int HH  = 5;

    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAW = 2, M_WAIT = 3, M_ERASE = 4;
    localparam int M_UPD  = 5, M_HIT  = 6, M_LEVEL = 7, M_OVER = 8, M_WIN = 9;

    localparam int C_UPDATE = 0, C_HIT = 1, C_DRAW = 2, C_ERASE5 = 3;
    localparam int C_RESPAWN = 4, C_NOHIT = 5, C_PIX7 = 6;

    logic       clock, reset, ld, collide, goal;
    logic       writeEnable, draw, update, respawn, hit, game_over, win;
    logic [3:0] pix_count;
    logic [1:0] lives, level;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 0;

    int  ph, left, idx, m_lives, m_level;
    bit  m_col, m_goal;

    game_control #(
        .FRAME_TICKS(FT), .PIXELS(PIX), .LIVES(LIV), .LEVELS(LVL), .HIT_HOLD(HH)
    ) dut (
        .clock(clock), .reset(reset), .ld(ld), .collide(collide), .goal(goal),
        .writeEnable(writeEnable), .draw(draw), .pix_count(pix_count),
        .update(update), .respawn(respawn), .lives(lives), .level(level),
        .hit(hit), .game_over(game_over), .win(win)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] dut_bundle();
        return 32'({writeEnable, draw, pix_count, update, respawn, lives, level,
                    hit, game_over, win});
    endfunction

    function automatic logic [31:0] exp_bundle();
        logic       we, dr, up, rs, ht, ov, wn;
        logic [3:0] pc;
        we = (ph == M_DRAW) || (ph == M_ERASE);
        dr = (ph == M_DRAW);
        pc = we ? 4'(idx) : 4'd0;
        up = (ph == M_UPD);
        rs = ((ph == M_HIT) && (left == 1) && (m_lives != 0)) ||
             ((ph == M_LEVEL) && (m_level != LVL));
        ht = (ph == M_HIT);
        ov = (ph == M_OVER);
        wn = (ph == M_WIN);
        return 32'({we, dr, pc, up, rs, 2'(m_lives), 2'(m_level), ht, ov, wn});
    endfunction

    function automatic void model_reset();
        ph = M_IDLE; left = 0; idx = 0; m_lives = 0; m_level = 0;
        m_col = 0; m_goal = 0;
    endfunction

    function automatic void model_step(bit l, bit c, bit g);
        bit rec;
        rec = (ph == M_DRAW) || (ph == M_WAIT) || (ph == M_ERASE) || (ph == M_UPD);
        case (ph)
            M_IDLE, M_OVER, M_WIN:
                if (l) begin ph = M_LOAD; m_lives = LIV; m_level = 1; end
            M_LOAD:
                if (!l) begin ph = M_DRAW; idx = 0; end
            M_DRAW, M_ERASE:
                if (idx == PIX - 1) begin
                    idx = 0;
                    if (ph == M_DRAW) begin ph = M_WAIT; left = FT; end
                    else ph = M_UPD;
                end else idx++;
            M_WAIT:
                if (left == 1) begin
                    rec = 0;
                    if (m_col) begin
                        ph = M_HIT; left = HH;
                        if (m_lives > 0) m_lives--;
                    end else if (m_goal) ph = M_LEVEL;
                    else begin ph = M_ERASE; idx = 0; end
                    m_col = 0; m_goal = 0;
                end else left--;
            M_UPD: begin ph = M_DRAW; idx = 0; end
            M_HIT:
                if (left == 1) begin
                    if (m_lives == 0) ph = M_OVER;
                    else begin ph = M_ERASE; idx = 0; end
                end else left--;
            M_LEVEL:
                if (m_level == LVL) ph = M_WIN;
                else begin m_level++; ph = M_ERASE; idx = 0; end
            default: ph = M_IDLE;
        endcase
        if (rec) begin
            m_col  = m_col | c;
            m_goal = m_goal | g;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    always @(negedge clock) begin
        if (chk_en) check("cycle", dut_bundle(), exp_bundle());
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else model_step(ld, collide, goal);
    endtask

    function automatic bit cond_true(input int c);
        case (c)
            C_UPDATE:  return update;
            C_HIT:     return hit;
            C_DRAW:    return draw;
            C_ERASE5:  return writeEnable && !draw && (pix_count == 4'd5);
            C_RESPAWN: return respawn;
            C_NOHIT:   return !hit;
            C_PIX7:    return draw && (pix_count == 4'd7);
            default:   return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int c, input int budget, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (cond_true(c)) begin ok = 1; break; end
            tick();
        end
        if (!ok) timeout(nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, r;
        bit rst_r;
        reset = 1'b1; ld = 1'b0; collide = 1'b0; goal = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_state", dut_bundle(), 32'd0);
        chk_en = 1;
        reset = 1'b0;

        // Start: ld held 3 cycles then the initial draw pass.
        ld = 1'b1;
        repeat (3) tick();
        check("load_we", 32'(writeEnable), 32'd0);
        check("load_lives", 32'(lives), 32'd3);
        check("load_level", 32'(level), 32'd1);
        ld = 1'b0;
        tick();
        n = 0;
        while (draw && n < 40) begin n++; tick(); end
        check("draw_len", n, 32'd16);

        // Free-running frame period and update pulse width.
        wait_until(C_UPDATE, 100, "wait_update");
        tick();
        check("update_width", 32'(update), 32'd0);
        n = 1;
        while (!update && n < 100) begin n++; tick(); end
        check("frame_period", n, 32'd37);

        // Collision and goal in the same frame: collision wins.
        wait_until(C_ERASE5, 100, "wait_erase5");
        collide = 1'b1; tick(); collide = 1'b0;
        goal = 1'b1; tick(); goal = 1'b0;
        wait_until(C_HIT, 100, "wait_hit1");
        check("hit_lives", 32'(lives), 32'd2);
        check("hit_level", 32'(level), 32'd1);
        n = 0; r = 0;
        while (hit && n < 50) begin n++; if (respawn) r++; tick(); end
        check("hit_len", n, 32'd5);
        check("hit_respawn", r, 32'd1);
        check("post_hit_erase", 32'({writeEnable, draw}), 32'b10);

        // Two more collisions end the game.
        for (int k = 0; k < 2; k++) begin
            wait_until(C_DRAW, 100, "wait_draw_col");
            collide = 1'b1; tick(); collide = 1'b0;
            wait_until(C_HIT, 100, "wait_hit_n");
            check("hit_lives_n", 32'(lives), (k == 0) ? 32'd1 : 32'd0);
            wait_until(C_NOHIT, 20, "wait_hit_end");
        end
        check("over_flag", 32'(game_over), 32'd1);
        check("over_we", 32'(writeEnable), 32'd0);
        check("over_lives", 32'(lives), 32'd0);
        repeat (5) tick();
        check("over_hold", 32'({game_over, lives}), 32'b100);
        ld = 1'b1; tick(); ld = 1'b0;
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_level", 32'(level), 32'd1);
        tick();
        check("restart_draw", 32'(draw), 32'd1);

        // Goal advances the level, then a second goal wins.
        goal = 1'b1; tick(); goal = 1'b0;
        wait_until(C_RESPAWN, 100, "wait_lvl_respawn");
        check("lvl_before", 32'(level), 32'd1);
        tick();
        check("lvl_after", 32'(level), 32'd2);
        check("lvl_erase", 32'({writeEnable, draw}), 32'b10);
        wait_until(C_DRAW, 100, "wait_draw_goal2");
        goal = 1'b1; tick(); goal = 1'b0;
        n = 0; r = 0;
        while (!win && n < 150) begin n++; if (respawn) r++; tick(); end
        if (!win) timeout("wait_win");
        check("win_level", 32'(level), 32'd2);
        check("win_no_respawn", r, 32'd0);

        // Asynchronous reset in the middle of a draw pass.
        ld = 1'b1; tick(); ld = 1'b0; tick();
        wait_until(C_PIX7, 40, "wait_pix7");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst", dut_bundle(), 32'd0);
        ld = 1'b1;
        repeat (3) tick();
        check("rst_ld_ignored", dut_bundle(), 32'd0);
        ld = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        check("post_rst_idle", dut_bundle(), 32'd0);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            ld      = ($urandom_range(0, 29) == 0);
            collide = ($urandom_range(0, 59) == 0);
            goal    = ($urandom_range(0, 59) == 0);
            rst_r   = ($urandom_range(0, 799) == 0);
            reset   = rst_r;
            if (rst_r) model_reset();
            tick();
        end
        reset = 1'b0; ld = 1'b0; collide = 1'b0; goal = 1'b0;
        tick();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Parametrised successor to the single-shot plot controller for the obstacle dodger game.
- Sequences a full per-frame erase/update/draw loop, paced by a frame-tick counter.
- Tracks lives and level, handles collision and goal events, and ends in a game-over or win state.
- Sits between the game input logic (start key, collision and goal detectors) and the VGA datapath; drives the plot enable, colour select and pixel offset.

Parameters:
- FRAME_TICKS, 833333, clock cycles per frame wait (>=2).
- PIXELS, 16, pixels per sprite plot pass (>=2).
- LIVES, 3, starting lives (>=1).
- LEVELS, 4, number of levels; clearing the last one wins (>=1).
- HIT_HOLD, 25000000, cycles the hit indication is held (>=1).
- Derived widths: PW=$clog2(PIXELS), LW=$clog2(LIVES+1), VW=$clog2(LEVELS+1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld  in  1  start key, level-sensitive
- collide  in  1  obstacle collision detected
- goal  in  1  object reached end of track
- writeEnable  out  1  VGA plot enable
- draw  out  1  1 = sprite colour, 0 = background (erase)
- pix_count  out  PW  pixel offset within the current plot pass
- update  out  1  one-cycle pulse: datapath advances object/obstacles
- respawn  out  1  one-cycle pulse: datapath returns object to start position
- lives  out  LW  remaining lives
- level  out  VW  current level, 1-based
- hit  out  1  high while in S_HIT
- game_over  out  1  high in S_OVER
- win  out  1  high in S_WIN

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, any state, mid-pass included): state=S_IDLE; all outputs 0; lives=0; level=0; counters and sticky flags cleared.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- S_IDLE: ld=1 -> S_LOAD. On that transition lives<=LIVES and level<=1.
- S_LOAD: hold while ld=1. ld=0 -> S_DRAW with pix_count=0 (initial draw).
- S_DRAW: writeEnable=1, draw=1. pix_count increments each cycle, 0..PIXELS-1, for exactly PIXELS cycles. After PIXELS-1 -> S_WAIT; pix_count<=0 and frame counter<=0.
- S_WAIT: writeEnable=0. Frame counter counts 0..FRAME_TICKS-1 (FRAME_TICKS cycles). On the terminal count:
  - col_flag set -> S_HIT, lives<=lives-1.
  - else goal_flag set -> S_LEVEL.
  - else -> S_ERASE.
  - Collision has priority over goal.
- Sticky flags: col_flag and goal_flag set on any cycle with collide/goal =1 while in S_DRAW, S_WAIT, S_ERASE or S_UPDATE. Both are cleared on the cycle the S_WAIT terminal decision is taken. Inputs are ignored in all other states.
- S_ERASE: writeEnable=1, draw=0, pix_count 0..PIXELS-1 over PIXELS cycles -> S_UPDATE.
- S_UPDATE: exactly 1 cycle, update=1 -> S_DRAW.
- S_HIT: hit=1 for HIT_HOLD cycles. Then:
  - lives==0 -> S_OVER.
  - else respawn=1 for one cycle, synchronous with the exit -> S_ERASE.
  - Lives never underflow: decrement only happens from lives>=1.
- S_LEVEL: 1 cycle.
  - level==LEVELS -> S_WIN; level unchanged.
  - else level<=level+1, respawn=1 -> S_ERASE.
- S_OVER / S_WIN: game_over / win =1, writeEnable=0, lives and level frozen. ld=1 -> S_LOAD, reloading lives=LIVES and level=1 (restart without reset).
- Unused state encodings -> S_IDLE.
- Total frame period in play = 2*PIXELS + FRAME_TICKS + 1 cycles when no event occurs.

Test Plan:
(params FRAME_TICKS=4, PIXELS=16, LIVES=3, LEVELS=2, HIT_HOLD=5)
1. Reset asserted, then ld high 3 cycles, then low -> S_LOAD held 3 cycles; then writeEnable=draw=1 for exactly 16 cycles with pix_count 0..15; lives=3, level=1.
2. Free run with no events -> repeating pattern: 16 draw, 4 wait, 16 erase (draw=0), 1 update pulse; period 37 cycles; update never 2 cycles wide.
3. collide pulsed 1 cycle mid-erase, goal pulsed same frame -> next WAIT terminal enters S_HIT (not S_LEVEL); lives=2; hit high 5 cycles; respawn 1 cycle; then erase pass.
4. Three collisions in three frames -> lives 2,1,0; after third S_HIT exits to game_over=1, writeEnable stays 0, lives stays 0; ld=1 -> lives=3, level=1, play resumes.
5. goal in frame N -> level 1->2 with respawn pulse; goal again -> win=1, level stays 2, no respawn.
6. reset asserted asynchronously (between clock edges) at pix_count=7 of a draw pass -> writeEnable, draw, pix_count, lives, level all 0 immediately; S_IDLE after release; ld ignored until reset deasserted.
